pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the hold/gap length inputs and internal down-counter.
REQ-002 SHALL have parameter MISS_W, default 8, width of missed_count.
REQ-003 SHALL have input clk, 1 bit, the clock; all state changes on its rising edge.
REQ-004 SHALL have input reset, 1 bit, the reset: synchronous, active-high.
REQ-005 SHALL have input update, 1 bit, a timebase strobe; hold/gap counting advances only in clk cycles with update=1.
REQ-006 SHALL have input tick, 1 bit, a stretch request, nominally one clk wide, sampled every clk cycle regardless of update.
REQ-007 SHALL have input hold_len, CNT_W bits, the number of update periods level stays high.
REQ-008 SHALL have input gap_len, CNT_W bits, the minimum number of update periods level stays low after a hold.
REQ-009 SHALL have input retrigger, 1 bit: 1 = tick during HOLD restarts the hold; 0 = tick during HOLD is queued.
REQ-010 SHALL have output level, 1 bit, the stretched output, registered, Moore (high iff state=HOLD).
REQ-011 SHALL have output busy, 1 bit, high iff state!=IDLE or pending=1.
REQ-012 SHALL have output missed, 1 bit, a one-clk pulse when a tick is dropped.
REQ-013 SHALL have output missed_count, MISS_W bits, a saturating count of dropped ticks.

Function
REQ-014 SHALL implement states IDLE, HOLD and GAP, with a CNT_W down-counter cnt and a single-entry pending flag.
REQ-015 SHALL treat hold_len=0 and gap_len=0 as 1; gap_len is forced to 1 or more so that a downstream edge detector always sees a low period.
REQ-016 SHALL sample hold_len only when cnt is loaded for HOLD, and gap_len only when cnt is loaded for GAP; changes at other times have no effect.
REQ-017 IDLE, tick=1: next state HOLD, cnt=max(hold_len,1), so level rises one clk after tick (latency 1).
REQ-018 HOLD, update=1, cnt>1, no accepted retrigger: cnt decrements by 1.
REQ-019 HOLD, update=1, cnt=1, no accepted retrigger: next state GAP, cnt=max(gap_len,1).
REQ-020 HOLD, tick=1, retrigger=1: cnt reloads to max(hold_len,1); the reload has priority over a same-cycle decrement or exit; pending is unchanged.
REQ-021 HOLD or GAP, tick=1, retrigger=0 (HOLD) or any retrigger (GAP), pending=0: pending is set.
REQ-022 Same condition as REQ-021 but pending=1: the tick is dropped, missed=1 for one clk, and missed_count increments, saturating at 2^MISS_W-1.
REQ-023 GAP, update=1, cnt>1: cnt decrements by 1.
REQ-024 GAP, update=1, cnt=1, with pending=1 or tick=1 that cycle: next state HOLD, cnt=max(hold_len,1), pending cleared; a same-cycle tick with pending=1 counts as dropped.
REQ-025 GAP, update=1, cnt=1, no pending and no tick: next state IDLE.
REQ-026 update=0: cnt and state are held, except for the tick-driven actions in REQ-017, REQ-020, REQ-021 and REQ-022.
REQ-027 SHALL drop level for at least one full update period between consecutive holds; this does not apply to retrigger extension.

Reset
REQ-028 reset=1 SHALL force state=IDLE, cnt=0, pending=0, level=0, missed=0 and missed_count=0 at the next clk edge, overriding every other input including tick.
REQ-029 Reset mid-HOLD SHALL drop level at the next edge without passing through GAP; the queued tick is discarded and not counted as missed.

Structure
REQ-030 A shared package SHALL hold the state encoding constants (IDLE, HOLD, GAP; 2-bit state register) and the LOW/HIGH bit constants.
REQ-031 The saturating missed counter SHALL be a sub-module sat_counter (parameter width; inputs clk, reset, inc; output count).
REQ-032 The FSM and cnt SHALL use a registered state with a separate combinational next-state block; outputs SHALL decode from registered state only.

Verification
REQ-033 reset, then hold_len=3, gap_len=2, update every clk, single tick -> level high exactly 3 clks starting 1 clk after tick, then low for 2 clks or more, busy low after GAP.
REQ-034 hold_len=4, retrigger=1, second tick 2 update periods into HOLD -> level high 6 update periods total, no missed pulse.
REQ-035 retrigger=0, 3 ticks during HOLD -> 1 queued, missed pulses twice, missed_count=2, queued hold starts right after gap_len periods low.
REQ-036 hold_len=0, gap_len=0, update every 4th clk -> level high 1 update period, low 1 update period or more.
REQ-037 reset asserted mid-HOLD with pending=1 -> level=0, busy=0 and missed_count=0 next clk, and a following tick restarts normally.
REQ-038 MISS_W=2, 5 dropped ticks -> missed_count saturates at 3 while missed still pulses each time.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared encodings for the pulse stretcher: FSM states and the output bit levels.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up-counter: counts inc strobes and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !(&count_q)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle ticks into hold_len-long high levels on an update timebase,
// with a guaranteed low gap between holds and a one-deep queue for extra ticks.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              update,
    input  logic              tick,
    input  logic [CNT_W-1:0]  hold_len,
    input  logic [CNT_W-1:0]  gap_len,
    input  logic              retrigger,
    output logic              level,
    output logic              busy,
    output logic              missed,
    output logic [MISS_W-1:0] missed_count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A zero length would give no low period for downstream edge detectors.
    function automatic logic [CNT_W-1:0] load_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? ONE : len;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             missed_q;
    logic             drop;
    logic             last;

    assign last = (cnt_q <= ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        drop    = LOW;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = HOLD;
                    cnt_d   = load_len(hold_len);
                end
            end

            HOLD: begin
                if (tick && retrigger) begin
                    cnt_d = load_len(hold_len);
                end else begin
                    if (tick) begin
                        if (pend_q) drop   = HIGH;
                        else        pend_d = HIGH;
                    end
                    if (update) begin
                        if (last) begin
                            state_d = GAP;
                            cnt_d   = load_len(gap_len);
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                end
            end

            GAP: begin
                if (update && last) begin
                    if (pend_q || tick) begin
                        state_d = HOLD;
                        cnt_d   = load_len(hold_len);
                        pend_d  = LOW;
                        drop    = tick && pend_q;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    // Ticks in GAP always queue; retrigger only extends a live hold.
                    if (tick) begin
                        if (pend_q) drop   = HIGH;
                        else        pend_d = HIGH;
                    end
                    if (update) begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_q   <= LOW;
            missed_q <= LOW;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            missed_q <= drop;
        end
    end

    sat_counter #(
        .WIDTH (MISS_W)
    ) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop),
        .count (missed_count)
    );

    assign level  = (state_q == HOLD) ? HIGH : LOW;
    assign busy   = (state_q != IDLE) || pend_q;
    assign missed = missed_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a vector table plus hand-written corner sequences.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       update = 1'b0;
    logic       tick = 1'b0;
    logic       retrigger = 1'b0;
    logic [7:0] hold_len = 8'd3;
    logic [7:0] gap_len = 8'd2;

    logic       level, busy, missed;
    logic [7:0] missed_count;
    logic       level2, busy2, missed2;
    logic [1:0] missed_count2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(.CNT_W(8), .MISS_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .update       (update),
        .tick         (tick),
        .hold_len     (hold_len),
        .gap_len      (gap_len),
        .retrigger    (retrigger),
        .level        (level),
        .busy         (busy),
        .missed       (missed),
        .missed_count (missed_count)
    );

    pulse_stretcher #(.CNT_W(8), .MISS_W(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .update       (update),
        .tick         (tick),
        .hold_len     (hold_len),
        .gap_len      (gap_len),
        .retrigger    (retrigger),
        .level        (level2),
        .busy         (busy2),
        .missed       (missed2),
        .missed_count (missed_count2)
    );

    typedef struct {
        logic       rst;
        logic       upd;
        logic       tk;
        logic       rt;
        logic [7:0] hl;
        logic [7:0] gl;
        logic       lvl;
        logic       bsy;
        logic       mis;
        logic [7:0] mc;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic upd, input logic tk, input logic rt,
                       input logic [7:0] hl, input logic [7:0] gl,
                       input logic lvl, input logic bsy, input logic mis,
                       input logic [7:0] mc, input string tag);
        vec_t v;
        v.rst = rst; v.upd = upd; v.tk = tk; v.rt = rt; v.hl = hl; v.gl = gl;
        v.lvl = lvl; v.bsy = bsy; v.mis = mis; v.mc = mc; v.tag = tag;
        vecs.push_back(v);
    endtask

    // One clock: drive inputs, take the edge, compare the registered outputs just after it.
    task automatic step(input logic rst, input logic upd, input logic tk, input logic rt,
                        input logic lvl, input logic bsy, input logic mis,
                        input logic [7:0] mc, input string tag);
        reset = rst; update = upd; tick = tk; retrigger = rt;
        @(posedge clk);
        #1;
        chk({tag, ".level"}, level, lvl);
        chk({tag, ".busy"}, busy, bsy);
        chk({tag, ".missed"}, missed, mis);
        chk({tag, ".missed_count"}, missed_count, mc);
    endtask

    initial begin
        // Basic hold/gap, hold=3 gap=2, update every clk.
        add(1,1,0,0, 3,2, 0,0,0,0, "rst");
        add(0,1,1,0, 3,2, 1,1,0,0, "a_tick");
        add(0,1,0,0, 3,2, 1,1,0,0, "a_h2");
        add(0,1,0,0, 3,2, 1,1,0,0, "a_h3");
        add(0,1,0,0, 3,2, 0,1,0,0, "a_g1");
        add(0,1,0,0, 3,2, 0,1,0,0, "a_g2");
        add(0,1,0,0, 3,2, 0,0,0,0, "a_idle");
        // Retrigger extension, hold=4: second tick two periods in.
        add(0,1,1,1, 4,2, 1,1,0,0, "b_tick");
        add(0,1,0,1, 4,2, 1,1,0,0, "b_h2");
        add(0,1,1,1, 4,2, 1,1,0,0, "b_retrig");
        add(0,1,0,1, 4,2, 1,1,0,0, "b_h4");
        add(0,1,0,1, 4,2, 1,1,0,0, "b_h5");
        add(0,1,0,1, 4,2, 1,1,0,0, "b_h6");
        add(0,1,0,1, 4,2, 0,1,0,0, "b_g1");
        add(0,1,0,1, 4,2, 0,1,0,0, "b_g2");
        add(0,1,0,1, 4,2, 0,0,0,0, "b_idle");
        // Zero lengths behave as one, update every 4th clk.
        add(0,1,1,0, 0,0, 1,1,0,0, "c_tick");
        add(0,0,0,0, 0,0, 1,1,0,0, "c_h2");
        add(0,0,0,0, 0,0, 1,1,0,0, "c_h3");
        add(0,0,0,0, 0,0, 1,1,0,0, "c_h4");
        add(0,1,0,0, 0,0, 0,1,0,0, "c_g1");
        add(0,0,0,0, 0,0, 0,1,0,0, "c_g2");
        add(0,0,0,0, 0,0, 0,1,0,0, "c_g3");
        add(0,0,0,0, 0,0, 0,1,0,0, "c_g4");
        add(0,1,0,0, 0,0, 0,0,0,0, "c_idle");

        for (int i = 0; i < vecs.size(); i++) begin
            hold_len = vecs[i].hl;
            gap_len  = vecs[i].gl;
            step(vecs[i].rst, vecs[i].upd, vecs[i].tk, vecs[i].rt,
                 vecs[i].lvl, vecs[i].bsy, vecs[i].mis, vecs[i].mc, vecs[i].tag);
        end

        // Queued ticks without retrigger: one queued, two dropped.
        hold_len = 8'd3; gap_len = 8'd2;
        step(1,1,0,0, 0,0,0,8'd0, "q_rst");
        step(0,1,1,0, 1,1,0,8'd0, "q_tick");
        step(0,1,1,0, 1,1,0,8'd0, "q_pend");
        step(0,1,1,0, 1,1,1,8'd1, "q_drop1");
        step(0,1,1,0, 0,1,1,8'd2, "q_drop2");
        step(0,1,0,0, 0,1,0,8'd2, "q_g2");
        step(0,1,0,0, 1,1,0,8'd2, "q_rehold");
        step(0,1,0,0, 1,1,0,8'd2, "q_h2");
        step(0,1,0,0, 1,1,0,8'd2, "q_h3");
        step(0,1,0,0, 0,1,0,8'd2, "q_g1b");
        step(0,1,0,0, 0,1,0,8'd2, "q_g2b");
        step(0,1,0,0, 0,0,0,8'd2, "q_idle");

        // Tick during GAP queues even with retrigger set; hold_len changed after load is ignored.
        hold_len = 8'd1; gap_len = 8'd3;
        step(1,1,0,1, 0,0,0,8'd0, "g_rst");
        step(0,1,1,1, 1,1,0,8'd0, "g_tick");
        hold_len = 8'd9;
        step(0,1,0,1, 0,1,0,8'd0, "g_gap");
        step(0,1,1,1, 0,1,0,8'd0, "g_queue");
        step(0,1,0,1, 0,1,0,8'd0, "g_g3");
        hold_len = 8'd1;
        step(0,1,0,1, 1,1,0,8'd0, "g_rehold");
        step(0,1,0,1, 0,1,0,8'd0, "g_gapb");

        // Reset mid-hold with a queued tick, overriding a same-cycle tick.
        hold_len = 8'd5; gap_len = 8'd2;
        step(1,1,0,0, 0,0,0,8'd0, "r_rst0");
        step(0,1,1,0, 1,1,0,8'd0, "r_tick");
        step(0,1,1,0, 1,1,0,8'd0, "r_pend");
        step(1,1,1,0, 0,0,0,8'd0, "r_reset");
        step(0,1,1,0, 1,1,0,8'd0, "r_restart");
        step(0,1,0,0, 1,1,0,8'd0, "r_h2");

        // Saturation on the 2-bit instance: five drops, update frozen.
        hold_len = 8'd20; gap_len = 8'd2;
        step(1,0,0,0, 0,0,0,8'd0, "s_rst");
        step(0,0,1,0, 1,1,0,8'd0, "s_tick");
        step(0,0,1,0, 1,1,0,8'd0, "s_pend");
        for (int k = 1; k <= 5; k++) begin
            step(0,0,1,0, 1,1,1,8'(k), $sformatf("s_drop%0d", k));
            chk($sformatf("s_drop%0d.missed2", k), missed2, 1);
            chk($sformatf("s_drop%0d.count2", k), missed_count2, (k < 3) ? k : 3);
        end
        step(0,0,0,0, 1,1,0,8'd5, "s_quiet");
        chk("s_quiet.missed2", missed2, 0);
        chk("s_quiet.count2", missed_count2, 3);
        step(1,0,0,0, 0,0,0,8'd0, "s_clear");
        chk("s_clear.count2", missed_count2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
